// File: rtl/clk_tick_gen_pkg.sv
// Shared definitions for the multi-channel clock-enable generator: default
// divisors, the write-decode result type and a constant log2 helper.
package clk_tick_gen_pkg;

  localparam int unsigned DIV_1KHZ = 12000;
  localparam int unsigned DIV_10HZ = 1200000;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACCEPT = 2'd1,
    WR_REJECT = 2'd2
  } wr_res_e;

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_tick_gen_if.sv
// Control/status bundle of clk_tick_gen: run enables, sync, divisor writes and
// the per-channel tick/square outputs.
interface clk_tick_gen_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 24,
  parameter int CH_W  = 2
);
  // Write handshake: wr_en is a one-cycle strobe with no ready; every strobe is
  // consumed on the edge it is seen, and wr_err pulses one cycle later if the
  // write was rejected.
  logic [N_CH-1:0]  ch_en;
  logic             sync;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             wr_err;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  sq;

  modport master (
    output ch_en, sync, wr_en, wr_ch, wr_div,
    input  wr_err, pend, tick, sq
  );

  modport slave (
    input  ch_en, sync, wr_en, wr_ch, wr_div,
    output wr_err, pend, tick, sq
  );
endinterface

// File: rtl/clk_tick_gen_chan.sv
// One divider channel: free-running counter, active/pending divisor, and the
// registered tick and square-wave outputs.
module clk_tick_gen_chan #(
  parameter int CNT_W = 24
) (
  input  logic             clk_12MHz,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] init_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_pend;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] sq_rise;
  logic             wrap;
  logic             apply;

  always_comb begin
    wrap    = (cnt == div_act - CNT_W'(1));
    apply   = !en || sync || wrap;
    cnt_inc = cnt + CNT_W'(1);
    // sq rises after ceil(div/2) low cycles
    sq_rise = div_act - (div_act >> 1);
  end

  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      div_act  <= init_div;
      div_pend <= '0;
      pend     <= 1'b0;
      tick     <= 1'b0;
      sq       <= 1'b0;
    end else if (apply) begin
      // Period boundary (wrap, stop or sync): the only place div_act may change
      cnt  <= '0;
      tick <= en && !sync;
      sq   <= 1'b0;
      pend <= 1'b0;
      if (wr_hit) begin
        div_act <= wr_div;
      end else if (pend) begin
        div_act <= div_pend;
      end
    end else begin
      cnt  <= cnt_inc;
      tick <= 1'b0;
      sq   <= (cnt_inc >= sq_rise);
      if (wr_hit) begin
        div_pend <= wr_div;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel programmable clock-enable generator: write decode, error pulse
// and N_CH divider channels sharing sync and the write bus.
module clk_tick_gen
  import clk_tick_gen_pkg::*;
#(
  parameter int                    N_CH     = 4,
  parameter int                    CNT_W    = 24,
  parameter int                    CH_W     = 2,
  parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {N_CH{CNT_W'(DIV_1KHZ)}}
) (
  input  logic        clk_12MHz,
  input  logic        reset,
  clk_tick_gen_if.slave bus
);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("clk_tick_gen: N_CH must be 1..16");
  end
  if (clog2(N_CH) > CH_W) begin : g_bad_ch_w
    $error("clk_tick_gen: CH_W too narrow to address N_CH channels");
  end

  wr_res_e          wr_res;
  logic             legal;
  logic             wr_err_q;
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  tick_w;
  logic [N_CH-1:0]  sq_w;
  logic [N_CH-1:0]  pend_w;

  always_comb begin
    legal  = (int'(bus.wr_ch) < N_CH) && (bus.wr_div >= CNT_W'(2));
    wr_res = WR_IDLE;
    if (bus.wr_en) begin
      wr_res = legal ? WR_ACCEPT : WR_REJECT;
    end
    wr_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = (wr_res == WR_ACCEPT) && (int'(bus.wr_ch) == i);
    end
  end

  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= (wr_res == WR_REJECT);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    if (DIV_INIT[i*CNT_W +: CNT_W] < CNT_W'(2)) begin : g_bad_init
      $error("clk_tick_gen: every DIV_INIT slice must be >= 2");
    end

    clk_tick_gen_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_12MHz (clk_12MHz),
      .reset     (reset),
      .en        (bus.ch_en[i]),
      .sync      (bus.sync),
      .wr_hit    (wr_hit[i]),
      .wr_div    (bus.wr_div),
      .init_div  (DIV_INIT[i*CNT_W +: CNT_W]),
      .tick      (tick_w[i]),
      .sq        (sq_w[i]),
      .pend      (pend_w[i])
    );
  end

  assign bus.wr_err = wr_err_q;
  assign bus.tick   = tick_w;
  assign bus.sq     = sq_w;
  assign bus.pend   = pend_w;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Bench for clk_tick_gen with two channels (reset divisors 4 and 5): directed
// cycle vectors feed an expected queue that a monitor drains after every edge.
module tb_clk_tick_gen;

  logic clk_12MHz;
  logic reset;

  clk_tick_gen_if #(.N_CH(2), .CNT_W(8), .CH_W(2)) bus ();

  clk_tick_gen #(
    .N_CH     (2),
    .CNT_W    (8),
    .CH_W     (2),
    .DIV_INIT ({8'd5, 8'd4})
  ) dut (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_12MHz = 1'b0;
    forever #5 clk_12MHz = ~clk_12MHz;
  end

  // ---------------- scoreboard ----------------
  // entry = {tick[1:0], sq[1:0], pend[1:0], wr_err}
  logic [6:0] exp_q[$];
  int         row_q[$];
  int         row_id = 0;
  int         n_cmp  = 0;
  int         n_err  = 0;

  always @(posedge clk_12MHz) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [6:0] exp_v;
      logic [6:0] got_v;
      int         rid;
      exp_v = exp_q.pop_front();
      rid   = row_q.pop_front();
      got_v = {bus.tick, bus.sq, bus.pend, bus.wr_err};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL row%0d: got tick=%b sq=%b pend=%b wr_err=%b, want tick=%b sq=%b pend=%b wr_err=%b",
                 rid, got_v[6:5], got_v[4:3], got_v[2:1], got_v[0],
                 exp_v[6:5], exp_v[4:3], exp_v[2:1], exp_v[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set at a falling edge; the expectation is for the next rising edge.
  task automatic cyc(input logic [1:0] en, input logic sy, input logic we,
                     input logic [1:0] wch, input logic [7:0] wdiv,
                     input logic [1:0] t, input logic [1:0] s,
                     input logic [1:0] p, input logic e);
    bus.ch_en  = en;
    bus.sync   = sy;
    bus.wr_en  = we;
    bus.wr_ch  = wch;
    bus.wr_div = wdiv;
    exp_q.push_back({t, s, p, e});
    row_q.push_back(row_id);
    row_id++;
    @(negedge clk_12MHz);
  endtask

  task automatic step(input logic [1:0] t, input logic [1:0] s,
                      input logic [1:0] p, input logic e);
    cyc(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, t, s, p, e);
  endtask

  task automatic wr(input logic [1:0] wch, input logic [7:0] wdiv,
                    input logic [1:0] t, input logic [1:0] s,
                    input logic [1:0] p, input logic e);
    cyc(2'b11, 1'b0, 1'b1, wch, wdiv, t, s, p, e);
  endtask

  // Default 4/5 pattern, k cycles after a fresh start:
  // ch0 ticks at k%4==0, sq0 high at k%4 in {2,3}; ch1 ticks at k%5==0, sq1 high at k%5 in {3,4}.
  task automatic run_free(input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      step({(k % 5) == 0, (k % 4) == 0}, {(k % 5) >= 3, (k % 4) >= 2}, 2'b00, 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b0;
    bus.ch_en  = 2'b00;
    bus.sync   = 1'b0;
    bus.wr_en  = 1'b0;
    bus.wr_ch  = 2'd0;
    bus.wr_div = 8'd0;
    repeat (2) @(negedge clk_12MHz);
    chk("reset_tick", {6'd0, bus.tick}, 8'd0);
    chk("reset_sq", {6'd0, bus.sq}, 8'd0);
    chk("reset_pend", {6'd0, bus.pend}, 8'd0);
    chk("reset_wr_err", {7'd0, bus.wr_err}, 8'd0);

    // free run at reset divisors
    bus.ch_en = 2'b11;
    reset     = 1'b1;
    run_free(1, 13);

    // ch0 <- 6 while cnt0=1: old 4-cycle period finishes first
    wr(2'd0, 8'd6, 2'b00, 2'b11, 2'b01, 1'b0);
    step(2'b10, 2'b01, 2'b01, 1'b0);
    step(2'b01, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b10, 2'b00, 1'b0);
    step(2'b00, 2'b11, 2'b00, 1'b0);
    step(2'b10, 2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b01, 2'b00, 1'b0);
    step(2'b01, 2'b00, 2'b00, 1'b0);

    // illegal writes: divisor 1, then channel 3
    wr(2'd0, 8'd1, 2'b00, 2'b10, 2'b00, 1'b1);
    step(2'b00, 2'b10, 2'b00, 1'b0);
    wr(2'd3, 8'd6, 2'b10, 2'b01, 2'b00, 1'b1);

    // ch0 back to 4, applied at the next ch0 wrap
    wr(2'd0, 8'd4, 2'b00, 2'b01, 2'b01, 1'b0);
    step(2'b00, 2'b01, 2'b01, 1'b0);
    step(2'b01, 2'b10, 2'b00, 1'b0);
    step(2'b00, 2'b10, 2'b00, 1'b0);
    step(2'b10, 2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b01, 2'b00, 1'b0);
    step(2'b01, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b10, 2'b00, 1'b0);
    step(2'b00, 2'b11, 2'b00, 1'b0);
    step(2'b10, 2'b01, 2'b00, 1'b0);
    step(2'b01, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b11, 2'b00, 1'b0);

    // sync with cnt0=2, cnt1=3; then 20 cycles, both tick together on the last
    cyc(2'b11, 1'b1, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
    run_free(1, 20);

    // ch1 <- 7, then ch1 disabled before its wrap
    wr(2'd1, 8'd7, 2'b00, 2'b00, 2'b10, 1'b0);
    step(2'b00, 2'b01, 2'b10, 1'b0);
    step(2'b00, 2'b11, 2'b10, 1'b0);
    cyc(2'b01, 1'b0, 1'b0, 2'd0, 8'd0, 2'b01, 2'b00, 2'b00, 1'b0);
    // sync while ch1 is disabled: ch0 restarts, ch1 stays idle
    cyc(2'b01, 1'b1, 1'b0, 2'd0, 8'd0, 2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 2'b01, 2'b00, 1'b0);
    step(2'b00, 2'b01, 2'b00, 1'b0);
    step(2'b01, 2'b10, 2'b00, 1'b0);
    step(2'b00, 2'b10, 2'b00, 1'b0);
    step(2'b00, 2'b11, 2'b00, 1'b0);
    step(2'b10, 2'b01, 2'b00, 1'b0);
    step(2'b01, 2'b00, 2'b00, 1'b0);

    // sync together with a ch1 write: applied directly, no pending state
    cyc(2'b11, 1'b1, 1'b1, 2'd1, 8'd5, 2'b00, 2'b00, 2'b00, 1'b0);
    run_free(1, 9);
    // k=10 with a pending ch0 write of 9 that the reset must discard
    wr(2'd0, 8'd9, 2'b10, 2'b01, 2'b01, 1'b0);

    // asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_tick", {6'd0, bus.tick}, 8'd0);
    chk("async_rst_sq", {6'd0, bus.sq}, 8'd0);
    chk("async_rst_pend", {6'd0, bus.pend}, 8'd0);
    chk("async_rst_wr_err", {7'd0, bus.wr_err}, 8'd0);
    @(negedge clk_12MHz);
    reset = 1'b1;
    run_free(1, 12);

    @(posedge clk_12MHz);
    #2;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: stimulus still running at %0t, want finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
